// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Byte/halfword/word load-store unit with unaligned access split
//            across two word-aligned memory cycles (read-modify-write stores).
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
    localparam logic [1:0] ACC1 = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;

    logic [2:0]  w_len;
    logic        w_cross;
    logic        w_acc;
    logic        w_phase;
    logic [31:0] w_base;
    logic [2:0]  w_k [4];
    logic [3:0]  w_cov;
    logic [31:0] w_wd;
    logic [31:0] w_ext;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
        return w[8*i +: 8];
    endfunction

    always_comb begin
        w_len = 3'd4;
        if (r_size == 2'b00)
            w_len = 3'd1;
        else if (r_size == 2'b01)
            w_len = 3'd2;
    end

    assign w_cross = ({1'b0, r_addr[1:0]} + w_len) > 3'd4;
    assign w_acc   = (r_state == ACC0) || (r_state == ACC1);
    assign w_phase = (r_state == ACC1);
    assign w_base  = {r_addr[31:2], 2'b00};

    // Lane l maps to access byte k = l + 4*phase - offset; a 3-bit wrap of a
    // negative k lands at 5..7, which is never below the length, so it is uncovered.
    generate
        for (genvar l = 0; l < 4; l++) begin : g_lane
            assign w_k[l]   = {1'b0, 2'(l)} + {w_phase, 2'b00} - {1'b0, r_addr[1:0]};
            assign w_cov[l] = w_acc && (w_k[l] < w_len);
            assign w_wd[8*l +: 8] = !(w_acc && r_we) ? 8'h00 :
                                    w_cov[l] ? sel_byte(r_wdata, w_k[l][1:0]) :
                                               mem_RD[8*l +: 8];
        end
    endgenerate

    assign req_ready = (r_state == IDLE);
    assign resp_valid = (r_state == DONE);
    assign mem_A  = (r_state == ACC0) ? w_base :
                    (r_state == ACC1) ? w_base + 32'd4 : 32'd0;
    assign mem_WD = w_wd;
    // Gating with rst keeps an aborted access from landing its pending write.
    assign mem_WE = w_acc && r_we && !rst;

    always_comb begin
        w_ext = r_buf;
        if (r_size == 2'b00)
            w_ext = {{24{~r_uns & r_buf[7]}}, r_buf[7:0]};
        else if (r_size == 2'b01)
            w_ext = {{16{~r_uns & r_buf[15]}}, r_buf[15:0]};
    end

    assign resp_rdata = (r_state == DONE && !r_we) ? w_ext : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_buf   <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_buf   <= 32'd0;
                        r_state <= ACC0;
                    end
                end
                ACC0:    r_state <= w_cross ? ACC1 : DONE;
                ACC1:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
            if (w_acc && !r_we) begin
                for (int l = 0; l < 4; l++) begin
                    if (w_cov[l])
                        r_buf[8*w_k[l][1:0] +: 8] <= mem_RD[8*l +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural word memory.
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    // Word index mem_A[4:2]: 0x0->0, 0x10->4, 0x14->5, 0xFFFFFFFC->7
    logic [31:0] mem [0:7];
    logic        tb_we;
    logic [2:0]  tb_a;
    logic [31:0] tb_d;

    always #5 clk = ~clk;

    assign mem_RD = mem[mem_A[4:2]];

    always @(posedge clk) begin
        if (tb_we)
            mem[tb_a] <= tb_d;
        else if (mem_WE) begin
            mem[mem_A[4:2]] <= mem_WD;
            wr_cnt <= wr_cnt + 1;
        end
    end

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [2:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_a = a; tb_d = d;
        step();
        tb_we = 1'b0;
    endtask

    // Presents a request in IDLE and clocks the handshake edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    int wr0;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        tb_we = 1'b0; tb_a = 3'd0; tb_d = 32'd0;
        step(); step();
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_we", {31'd0, mem_WE}, 32'd0);
        chk("rst_A", mem_A, 32'd0);
        chk("rst_WD", mem_WD, 32'd0);
        rst = 1'b0;

        // Byte signed load at 0x13
        poke(3'd4, 32'h8899AABB);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
        chk("lb_acc0_A", mem_A, 32'h10);
        chk("lb_acc0_we", {31'd0, mem_WE}, 32'd0);
        chk("lb_acc0_ready", {31'd0, req_ready}, 32'd0);
        chk("lb_acc0_rv", {31'd0, resp_valid}, 32'd0);
        step();
        chk("lb_done_rv", {31'd0, resp_valid}, 32'd1);
        chk("lb_done_rdata", resp_rdata, 32'hFFFFFF88);
        chk("lb_done_A", mem_A, 32'd0);
        step();
        chk("lb_idle_rv", {31'd0, resp_valid}, 32'd0);
        chk("lb_idle_rdata", resp_rdata, 32'd0);

        // Halfword unsigned at 0x12
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'd0);
        step();
        chk("lhu_rv", {31'd0, resp_valid}, 32'd1);
        chk("lhu_rdata", resp_rdata, 32'h00008899);
        step();

        // Halfword signed at 0x10 and byte unsigned at 0x10
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'd0);
        step();
        chk("lh_rdata", resp_rdata, 32'hFFFFAABB);
        step();
        issue(1'b0, 2'b00, 1'b1, 32'h10, 32'd0);
        step();
        chk("lbu_rdata", resp_rdata, 32'h000000BB);
        step();

        // Crossing word load at 0x13
        poke(3'd4, 32'h44332211);
        poke(3'd5, 32'h88776655);
        issue(1'b0, 2'b10, 1'b0, 32'h13, 32'd0);
        chk("lw_acc0_A", mem_A, 32'h10);
        step();
        chk("lw_acc1_A", mem_A, 32'h14);
        chk("lw_acc1_rv", {31'd0, resp_valid}, 32'd0);
        step();
        chk("lw_done_rv", {31'd0, resp_valid}, 32'd1);
        chk("lw_rdata", resp_rdata, 32'h77665544);
        step();

        // Halfword store at 0x11
        poke(3'd4, 32'h00000000);
        wr0 = wr_cnt;
        issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234ABCD);
        chk("sh_we", {31'd0, mem_WE}, 32'd1);
        chk("sh_A", mem_A, 32'h10);
        chk("sh_WD", mem_WD, 32'h00ABCD00);
        step();
        chk("sh_done_rv", {31'd0, resp_valid}, 32'd1);
        chk("sh_done_rdata", resp_rdata, 32'd0);
        chk("sh_done_we", {31'd0, mem_WE}, 32'd0);
        chk("sh_mem", mem[4], 32'h00ABCD00);
        chk("sh_wr_cnt", wr_cnt - wr0, 32'd1);
        step();

        // Wrapping crossing word store at 0xFFFFFFFE
        poke(3'd7, 32'd0);
        poke(3'd0, 32'd0);
        issue(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'hDEADBEEF);
        chk("sw_acc0_A", mem_A, 32'hFFFFFFFC);
        chk("sw_acc0_WD", mem_WD, 32'hBEEF0000);
        chk("sw_acc0_we", {31'd0, mem_WE}, 32'd1);
        step();
        chk("sw_acc1_A", mem_A, 32'h00000000);
        chk("sw_acc1_WD", mem_WD, 32'h0000DEAD);
        step();
        chk("sw_done_rv", {31'd0, resp_valid}, 32'd1);
        chk("sw_mem_hi", mem[7], 32'hBEEF0000);
        chk("sw_mem_lo", mem[0], 32'h0000DEAD);
        step();

        // Same store aborted by reset during ACC1
        poke(3'd7, 32'd0);
        poke(3'd0, 32'd0);
        wr0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'hDEADBEEF);
        step();
        chk("abort_acc1_A", mem_A, 32'h00000000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_rv", {31'd0, resp_valid}, 32'd0);
        step();
        chk("abort_rv_later", {31'd0, resp_valid}, 32'd0);
        chk("abort_mem_hi", mem[7], 32'hBEEF0000);
        chk("abort_mem_lo", mem[0], 32'd0);
        chk("abort_wr_cnt", wr_cnt - wr0, 32'd1);

        // Reset wins over a simultaneous handshake
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        step();
        rst = 1'b0; req_valid = 1'b0;
        chk("rstprio_ready", {31'd0, req_ready}, 32'd1);
        chk("rstprio_A", mem_A, 32'd0);
        step();
        chk("rstprio_rv", {31'd0, resp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
